gigatron_pad_serializer: RTL and testbench

- Emulates the Famicom serial game controller seen by the Gigatron shell.
- Each Gigatron frame it returns one active-low input byte, merged from two sources:
  - the live joystick;
  - a queued stream of ASCII keystrokes.
- Each keystroke is held for a fixed number of frames, then followed by an idle gap, so the Gigatron ROM sees every key exactly once.
- Sits between the keyboard decoder / joystick inputs and the shell's famicom_latch/famicom_pulse/famicom_data pins.

---
 rtl/gigatron_input_pkg.sv | 28 ++
 rtl/pad_key_fifo.sv | 69 ++++++
 rtl/gigatron_pad_serializer.sv | 133 +++++++++++++
 tb/tb_gigatron_pad_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_input_pkg.sv
// Shared types and constants for the Gigatron controller input path.
// Pad bytes are active-low on the serial side; joystick bits are 1 = pressed.
package gigatron_input_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_HOLD,
    PS_GAP
  } pad_state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // Pressed buttons pull their bit low on top of the key byte.
  function automatic logic [7:0] merge_pad(input logic [7:0] key_byte,
                                           input logic [7:0] joy_byte);
    return key_byte & ~joy_byte;
  endfunction

endpackage

// File: rtl/pad_key_fifo.sv
// Show-ahead synchronous keystroke FIFO; pop data valid whenever !empty.
// Pushes are ignored while full and pops while empty; simultaneous push/pop keeps the level.
module pad_key_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  output logic [7:0]    pop_dat,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Power-of-two depth lets the pointers wrap naturally.
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gigatron_pad_serializer.sv
// Famicom-style serial pad for the Gigatron: merges joystick and queued keystrokes.
// Pin edge to famicom_data change is 2 cycles; key_ready drops only while the queue is full.
module gigatron_pad_serializer
  import gigatron_input_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_FRAMES = 3,
  parameter int GAP_FRAMES  = 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  output logic          key_ready,
  input  logic [7:0]    joy_byte,
  input  logic          famicom_latch,
  input  logic          famicom_pulse,
  output logic          famicom_data,
  output logic [LW-1:0] fifo_level,
  output logic          busy
);

  localparam int CNT_MAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic          lat_q, lat_qq, pul_q, pul_qq;
  logic [7:0]    sr_q, sr_d;
  pad_state_t    state_q, state_d;
  logic [7:0]    cur_key_q, cur_key_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [7:0]    key_byte, pad_byte;
  logic          frame_tick, pul_rise;

  assign key_ready = ~fifo_full;
  assign fifo_push = key_valid & key_ready;

  pad_key_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .push_dat(key_ascii),
    .pop     (fifo_pop),
    .pop_dat (fifo_dat),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign frame_tick = ~lat_q & lat_qq;
  assign pul_rise   = pul_q & ~pul_qq;
  assign key_byte   = (state_q == PS_HOLD) ? cur_key_q : IDLE_BYTE;
  assign pad_byte   = merge_pad(key_byte, joy_byte);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    cur_key_d   = cur_key_q;
    fifo_pop    = 1'b0;
    case (state_q)
      PS_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cur_key_d   = fifo_dat;
          frame_cnt_d = '0;
          state_d     = PS_HOLD;
        end
      end
      PS_HOLD: begin
        if (frame_tick) begin
          if (frame_cnt_q == CW'(HOLD_FRAMES - 1)) begin
            frame_cnt_d = '0;
            state_d     = PS_GAP;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      PS_GAP: begin
        if (frame_tick) begin
          if (frame_cnt_q == CW'(GAP_FRAMES - 1)) begin
            frame_cnt_d = '0;
            state_d     = PS_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  // Latch wins over pulse; shifted-in 1s keep extra pulses reading as released.
  always_comb begin
    sr_d = sr_q;
    if (lat_q) begin
      sr_d = pad_byte;
    end else if (pul_rise) begin
      sr_d = {sr_q[6:0], 1'b1};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lat_q       <= 1'b0;
      lat_qq      <= 1'b0;
      pul_q       <= 1'b0;
      pul_qq      <= 1'b0;
      sr_q        <= IDLE_BYTE;
      state_q     <= PS_IDLE;
      cur_key_q   <= IDLE_BYTE;
      frame_cnt_q <= '0;
    end else begin
      lat_q       <= famicom_latch;
      lat_qq      <= lat_q;
      pul_q       <= famicom_pulse;
      pul_qq      <= pul_q;
      sr_q        <= sr_d;
      state_q     <= state_d;
      cur_key_q   <= cur_key_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign famicom_data = sr_q[7];
  assign busy         = (state_q != PS_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_gigatron_pad_serializer.sv
// Frame-level bench: joystick table vectors plus a key-byte scoreboard for queued keystrokes.
`timescale 1ns/1ps
module tb_gigatron_pad_serializer;
  import gigatron_input_pkg::*;

  localparam int FIFO_DEPTH  = 8;
  localparam int HOLD_FRAMES = 3;
  localparam int GAP_FRAMES  = 2;
  localparam int LW          = $clog2(FIFO_DEPTH + 1);

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          key_valid;
  logic [7:0]    key_ascii;
  logic          key_ready;
  logic [7:0]    joy_byte;
  logic          famicom_latch;
  logic          famicom_pulse;
  logic          famicom_data;
  logic [LW-1:0] fifo_level;
  logic          busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    exp_q[$];

  typedef struct {
    logic [7:0] joy;
    logic [7:0] exp;
  } joy_vec_t;
  joy_vec_t vecs[6];

  always #5 clk_sys = ~clk_sys;

  gigatron_pad_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_FRAMES(HOLD_FRAMES),
    .GAP_FRAMES (GAP_FRAMES)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_ascii    (key_ascii),
    .key_ready    (key_ready),
    .joy_byte     (joy_byte),
    .famicom_latch(famicom_latch),
    .famicom_pulse(famicom_pulse),
    .famicom_data (famicom_data),
    .fifo_level   (fifo_level),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // A queued key is presented for HOLD_FRAMES latches, then the idle byte for GAP_FRAMES.
  task automatic expect_key(input logic [7:0] k);
    for (int i = 0; i < HOLD_FRAMES; i++) exp_q.push_back(k);
    for (int i = 0; i < GAP_FRAMES; i++) exp_q.push_back(IDLE_BYTE);
  endtask

  task automatic push_key(input logic [7:0] k);
    int waited;
    waited    = 0;
    key_valid = 1'b1;
    key_ascii = k;
    while (!key_ready && waited < 200) begin
      @(negedge clk_sys);
      waited++;
    end
    check("push_accept", key_ready, 1);
    @(negedge clk_sys);
    key_valid = 1'b0;
    expect_key(k);
  endtask

  task automatic do_frame(output logic [7:0] b);
    famicom_latch = 1'b1;
    repeat (4) @(negedge clk_sys);
    famicom_latch = 1'b0;
    repeat (3) @(negedge clk_sys);
    for (int i = 7; i >= 0; i--) begin
      b[i] = famicom_data;
      famicom_pulse = 1'b1;
      repeat (3) @(negedge clk_sys);
      famicom_pulse = 1'b0;
      repeat (3) @(negedge clk_sys);
    end
  endtask

  task automatic frame_sb(input string name);
    logic [7:0] b;
    logic [7:0] want;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_BYTE;
    want = want & ~joy_byte;
    do_frame(b);
    check(name, b, want);
  endtask

  initial begin
    logic [7:0] b;

    vecs[0] = '{joy: 8'h00, exp: 8'hFF};
    vecs[1] = '{joy: 8'h88, exp: 8'h77};
    vecs[2] = '{joy: 8'h80, exp: 8'h7F};
    vecs[3] = '{joy: 8'h01, exp: 8'hFE};
    vecs[4] = '{joy: 8'hFF, exp: 8'h00};
    vecs[5] = '{joy: 8'h5A, exp: 8'hA5};

    reset         = 1'b1;
    key_valid     = 1'b0;
    key_ascii     = 8'h00;
    joy_byte      = 8'h00;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("reset_data", famicom_data, 1);
    check("reset_key_ready", key_ready, 1);
    check("reset_level", fifo_level, 0);
    check("reset_busy", busy, 0);
    do_frame(b);
    check("reset_frame", b, 8'hFF);

    for (int i = 0; i < 6; i++) begin
      joy_byte = vecs[i].joy;
      do_frame(b);
      check($sformatf("joy_vec%0d", i), b, vecs[i].exp);
    end
    joy_byte = 8'h00;

    push_key(8'h41);
    for (int f = 1; f <= 6; f++) begin
      frame_sb($sformatf("keyA_f%0d", f));
      if (f == 4) check("keyA_busy_gap", busy, 1);
      if (f == 5) check("keyA_busy_done", busy, 0);
    end

    // Joystick stays merged through both hold and gap frames.
    joy_byte = 8'h01;
    push_key(8'h48);
    push_key(8'h49);
    check("hi_level_q", fifo_level, 1);
    for (int f = 1; f <= 10; f++) begin
      frame_sb($sformatf("hi_f%0d", f));
      if (f == 5) begin
        check("hi_level_after_pop", fifo_level, 0);
        check("hi_busy_mid", busy, 1);
      end
    end
    check("hi_busy_end", busy, 0);
    joy_byte = 8'h00;

    // First key is popped into the hold slot, the next eight fill the queue.
    for (int i = 0; i < 9; i++) push_key(8'h30 + 8'(i));
    key_valid = 1'b1;
    key_ascii = 8'h39;
    @(negedge clk_sys);
    check("full_key_ready", key_ready, 0);
    check("full_level", fifo_level, FIFO_DEPTH);
    @(negedge clk_sys);
    check("full_hold_level", fifo_level, FIFO_DEPTH);
    key_valid = 1'b0;
    for (int f = 1; f <= 5; f++) frame_sb($sformatf("full_k0_f%0d", f));
    check("after_pop_level", fifo_level, FIFO_DEPTH - 1);
    check("after_pop_ready", key_ready, 1);
    push_key(8'h39);
    check("refill_level", fifo_level, FIFO_DEPTH);
    for (int f = 0; f < 60 && exp_q.size() > 0; f++) frame_sb($sformatf("drain_f%0d", f));
    check("drain_empty_sb", exp_q.size(), 0);
    check("drain_level", fifo_level, 0);
    check("drain_busy", busy, 0);

    push_key(8'h5A);
    push_key(8'h59);
    check("pre_reset_level", fifo_level, 1);
    famicom_latch = 1'b1;
    repeat (4) @(negedge clk_sys);
    famicom_latch = 1'b0;
    repeat (3) @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      famicom_pulse = 1'b1;
      repeat (3) @(negedge clk_sys);
      famicom_pulse = 1'b0;
      repeat (3) @(negedge clk_sys);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk_sys);
    check("midreset_data", famicom_data, 1);
    check("midreset_level", fifo_level, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", key_ready, 1);
    frame_sb("midreset_frame1");
    frame_sb("midreset_frame2");
    check("midreset_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
